// File: rtl/pe_ctrl_pkg.sv
// Shared control definitions for the PE scratchpad sequencer:
// FSM state encoding, drain default and loop-bound helper.
package pe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_WIN = 3'd1,
    ST_READ     = 3'd2,
    ST_DRAIN    = 3'd3,
    ST_OUT      = 3'd4
  } seq_state_e;

  localparam int DRAIN_CYC_DEFAULT = 2;
  localparam int DRAIN_CNT_W       = 8;

  // Terminal index for a loop bound; a bound of zero runs one iteration.
  function automatic logic [15:0] bound_to_max(input logic [15:0] cfg);
    return (cfg == 16'd0) ? 16'd0 : cfg - 16'd1;
  endfunction

endpackage

// File: rtl/pe_loop_counter.sv
// Saturating loop-index counter: counts up while enabled, holds at max_count.
module pe_loop_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] max_count,
  output logic [W-1:0] count,
  output logic         at_max
);

  assign at_max = (count >= max_count);

  // Index register; clear has priority over counting.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= {W{1'b0}};
    end else if (clear) begin
      count <= {W{1'b0}};
    end else if (en && !at_max) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/pe_spad_seq.sv
// Scratchpad read sequencer for one PE: walks filter taps (s) within
// channels (c) for each window (w), drives the MAC and hands off psums.
module pe_spad_seq
  import pe_ctrl_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int ADDR_W    = 8,
  parameter int DRAIN_CYC = DRAIN_CYC_DEFAULT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_filt_len,
  input  logic [CNT_W-1:0]  cfg_num_ch,
  input  logic [CNT_W-1:0]  cfg_num_win,
  input  logic              win_valid,
  output logic              win_ready,
  output logic              spad_rd_en,
  output logic [ADDR_W-1:0] spad_addr,
  output logic              mac_en,
  output logic              mac_first,
  output logic              psum_valid,
  input  logic              psum_ready,
  output logic              busy,
  output logic              done
);

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST =
    DRAIN_CNT_W'((DRAIN_CYC > 1) ? (DRAIN_CYC - 1) : 0);

  seq_state_e state;
  seq_state_e state_next;

  logic [CNT_W-1:0]       s_max;
  logic [CNT_W-1:0]       c_max;
  logic [CNT_W-1:0]       w_max;
  logic [CNT_W-1:0]       s_idx;
  logic [CNT_W-1:0]       c_idx;
  logic [CNT_W-1:0]       win_idx_unused;
  logic                   s_at_max;
  logic                   c_at_max;
  logic                   w_at_max;
  logic [ADDR_W-1:0]      base;
  logic [DRAIN_CNT_W-1:0] drain_cnt;

  logic start_acc;
  logic win_hs;
  logic psum_hs;
  logic in_read;
  logic s_wrap;

  // A start coinciding with done is dropped so a pass cannot chain implicitly.
  assign start_acc = (state == ST_IDLE) && start && !done;
  assign win_hs    = (state == ST_WAIT_WIN) && win_valid;
  assign psum_hs   = (state == ST_OUT) && psum_ready;
  assign in_read   = (state == ST_READ);
  assign s_wrap    = in_read && s_at_max;

  pe_loop_counter #(.W(CNT_W)) u_s_cnt (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (start_acc || win_hs || s_wrap),
    .en        (in_read),
    .max_count (s_max),
    .count     (s_idx),
    .at_max    (s_at_max)
  );

  pe_loop_counter #(.W(CNT_W)) u_c_cnt (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (start_acc || win_hs),
    .en        (s_wrap),
    .max_count (c_max),
    .count     (c_idx),
    .at_max    (c_at_max)
  );

  pe_loop_counter #(.W(CNT_W)) u_w_cnt (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (start_acc),
    .en        (psum_hs),
    .max_count (w_max),
    .count     (win_idx_unused),
    .at_max    (w_at_max)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start_acc) state_next = ST_WAIT_WIN;
        else           state_next = ST_IDLE;
      end
      ST_WAIT_WIN: begin
        if (win_valid) state_next = ST_READ;
        else           state_next = ST_WAIT_WIN;
      end
      ST_READ: begin
        if (s_at_max && c_at_max) state_next = ST_DRAIN;
        else                      state_next = ST_READ;
      end
      ST_DRAIN: begin
        if (drain_cnt >= DRAIN_LAST) state_next = ST_OUT;
        else                         state_next = ST_DRAIN;
      end
      ST_OUT: begin
        if (psum_ready) state_next = w_at_max ? ST_IDLE : ST_WAIT_WIN;
        else            state_next = ST_OUT;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State-decoded outputs; the address is zero outside READ.
  always_comb begin
    win_ready  = 1'b0;
    spad_rd_en = 1'b0;
    spad_addr  = {ADDR_W{1'b0}};
    psum_valid = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_WAIT_WIN: win_ready = 1'b1;
      ST_READ: begin
        spad_rd_en = 1'b1;
        spad_addr  = base + ADDR_W'(s_idx);
      end
      ST_OUT:  psum_valid = 1'b1;
      default: win_ready = 1'b0;
    endcase
  end

  // Loop bounds are frozen for the whole pass.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s_max <= {CNT_W{1'b0}};
      c_max <= {CNT_W{1'b0}};
      w_max <= {CNT_W{1'b0}};
    end else if (start_acc) begin
      s_max <= CNT_W'(bound_to_max(16'(cfg_filt_len)));
      c_max <= CNT_W'(bound_to_max(16'(cfg_num_ch)));
      w_max <= CNT_W'(bound_to_max(16'(cfg_num_win)));
    end else begin
      s_max <= s_max;
      c_max <= c_max;
      w_max <= w_max;
    end
  end

  // Channel base address steps by S so spad_addr = c*S + s without a multiplier.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      base <= {ADDR_W{1'b0}};
    end else if (start_acc || win_hs) begin
      base <= {ADDR_W{1'b0}};
    end else if (s_wrap && !c_at_max) begin
      base <= base + ADDR_W'(s_max) + ADDR_W'(1);
    end else begin
      base <= base;
    end
  end

  // Drain timer plus the MAC controls and done pulse, one cycle behind the reads.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      drain_cnt <= {DRAIN_CNT_W{1'b0}};
      mac_en    <= 1'b0;
      mac_first <= 1'b0;
      done      <= 1'b0;
    end else begin
      drain_cnt <= (state == ST_DRAIN) ? (drain_cnt + DRAIN_CNT_W'(1)) : {DRAIN_CNT_W{1'b0}};
      mac_en    <= spad_rd_en;
      mac_first <= spad_rd_en && (s_idx == {CNT_W{1'b0}}) && (c_idx == {CNT_W{1'b0}});
      done      <= psum_hs && w_at_max;
    end
  end

endmodule

// File: tb/tb_pe_spad_seq.sv
// Directed self-checking bench for pe_spad_seq (CNT_W=4, ADDR_W=8, DRAIN_CYC=2).
module tb_pe_spad_seq;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic [3:0] cfg_filt_len = 4'd0;
  logic [3:0] cfg_num_ch = 4'd0;
  logic [3:0] cfg_num_win = 4'd0;
  logic       win_valid = 1'b0;
  logic       win_ready;
  logic       spad_rd_en;
  logic [7:0] spad_addr;
  logic       mac_en;
  logic       mac_first;
  logic       psum_valid;
  logic       psum_ready = 1'b0;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int rd_cnt = 0;
  int win_cnt = 0;
  int psum_cnt = 0;

  pe_spad_seq #(.CNT_W(4), .ADDR_W(8), .DRAIN_CYC(2)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .cfg_filt_len (cfg_filt_len),
    .cfg_num_ch   (cfg_num_ch),
    .cfg_num_win  (cfg_num_win),
    .win_valid    (win_valid),
    .win_ready    (win_ready),
    .spad_rd_en   (spad_rd_en),
    .spad_addr    (spad_addr),
    .mac_en       (mac_en),
    .mac_first    (mac_first),
    .psum_valid   (psum_valid),
    .psum_ready   (psum_ready),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (spad_rd_en) rd_cnt++;
    if (win_ready && win_valid) win_cnt++;
    if (psum_valid && psum_ready) psum_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [3:0] s, input logic [3:0] c, input logic [3:0] w);
    cfg_filt_len = s;
    cfg_num_ch   = c;
    cfg_num_win  = w;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    rstn = 1'b0;
    step();
    step();
    obs = {win_ready, spad_rd_en, mac_en, mac_first, psum_valid, busy, done};
    checks++;
    if (obs !== 7'b0) begin failures++; $display("FAIL reset_outputs got=%b exp=%b", obs, 7'b0); end
    checks++;
    if (spad_addr !== 8'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", spad_addr); end
    rstn = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_single();
    int d0;
    d0 = done_cnt;
    psum_ready = 1'b1;
    kick(4'd3, 4'd2, 4'd1);
    checks++;
    if ({busy, win_ready} !== 2'b11) begin failures++; $display("FAIL single_wait got=%b exp=11", {busy, win_ready}); end
    win_valid = 1'b1;
    step();
    win_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if ({spad_rd_en, spad_addr} !== {1'b1, 8'(i)}) begin
        failures++; $display("FAIL single_addr[%0d] got=%b/%0d exp=1/%0d", i, spad_rd_en, spad_addr, i);
      end
      checks++;
      if ({mac_en, mac_first} !== {(i > 0), (i == 1)}) begin
        failures++; $display("FAIL single_mac[%0d] got=%b exp=%b", i, {mac_en, mac_first}, {(i > 0), (i == 1)});
      end
      step();
    end
    checks++;
    if ({spad_rd_en, mac_en, mac_first, psum_valid} !== 4'b0100) begin
      failures++; $display("FAIL single_last_mac got=%b exp=0100", {spad_rd_en, mac_en, mac_first, psum_valid});
    end
    step();
    checks++;
    if ({mac_en, psum_valid} !== 2'b00) begin failures++; $display("FAIL single_drain got=%b exp=00", {mac_en, psum_valid}); end
    step();
    checks++;
    if ({psum_valid, done} !== 2'b10) begin failures++; $display("FAIL single_psum got=%b exp=10", {psum_valid, done}); end
    step();
    checks++;
    if ({done, busy, psum_valid} !== 3'b100) begin failures++; $display("FAIL single_done got=%b exp=100", {done, busy, psum_valid}); end
    step();
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL single_done_pulse got=%b exp=0", done); end
    checks++;
    if (done_cnt - d0 !== 1) begin failures++; $display("FAIL single_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_multi();
    int d0;
    int w0;
    int p0;
    d0 = done_cnt;
    w0 = win_cnt;
    p0 = psum_cnt;
    psum_ready = 1'b0;
    kick(4'd2, 4'd1, 4'd3);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (win_ready !== 1'b1) begin failures++; $display("FAIL multi_win_ready[%0d] got=%b exp=1", k, win_ready); end
      win_valid = 1'b1;
      step();
      win_valid = 1'b0;
      checks++;
      if ({spad_rd_en, spad_addr} !== {1'b1, 8'd0}) begin failures++; $display("FAIL multi_addr0[%0d] got=%0d exp=0", k, spad_addr); end
      step();
      checks++;
      if ({spad_addr, mac_first} !== {8'd1, 1'b1}) begin
        failures++; $display("FAIL multi_addr1[%0d] got=%0d/%b exp=1/1", k, spad_addr, mac_first);
      end
      step();
      step();
      step();
      for (int j = 0; j < 5; j++) begin
        checks++;
        if ({psum_valid, win_ready, spad_rd_en, mac_en, done, busy} !== 6'b100001) begin
          failures++; $display("FAIL multi_stall[%0d.%0d] got=%b exp=100001", k, j,
                               {psum_valid, win_ready, spad_rd_en, mac_en, done, busy});
        end
        step();
      end
      checks++;
      if (psum_valid !== 1'b1) begin failures++; $display("FAIL multi_hold[%0d] got=%b exp=1", k, psum_valid); end
      psum_ready = 1'b1;
      step();
      psum_ready = 1'b0;
      if (k < 2) begin
        checks++;
        if ({win_ready, done} !== 2'b10) begin failures++; $display("FAIL multi_next[%0d] got=%b exp=10", k, {win_ready, done}); end
      end else begin
        checks++;
        if ({done, busy} !== 2'b10) begin failures++; $display("FAIL multi_done got=%b exp=10", {done, busy}); end
      end
    end
    step();
    step();
    checks++;
    if (done_cnt - d0 !== 1) begin failures++; $display("FAIL multi_done_count got=%0d exp=1", done_cnt - d0); end
    checks++;
    if (win_cnt - w0 !== 3) begin failures++; $display("FAIL multi_win_count got=%0d exp=3", win_cnt - w0); end
    checks++;
    if (psum_cnt - p0 !== 3) begin failures++; $display("FAIL multi_psum_count got=%0d exp=3", psum_cnt - p0); end
  endtask

  task automatic test_zero();
    int d0;
    int r0;
    int p0;
    d0 = done_cnt;
    r0 = rd_cnt;
    p0 = psum_cnt;
    psum_ready = 1'b1;
    kick(4'd0, 4'd0, 4'd0);
    win_valid = 1'b1;
    step();
    win_valid = 1'b0;
    checks++;
    if ({spad_rd_en, spad_addr} !== {1'b1, 8'd0}) begin failures++; $display("FAIL zero_read got=%b/%0d exp=1/0", spad_rd_en, spad_addr); end
    step();
    checks++;
    if ({spad_rd_en, mac_en, mac_first} !== 3'b011) begin
      failures++; $display("FAIL zero_mac got=%b exp=011", {spad_rd_en, mac_en, mac_first});
    end
    step();
    step();
    checks++;
    if (psum_valid !== 1'b1) begin failures++; $display("FAIL zero_psum got=%b exp=1", psum_valid); end
    step();
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b exp=1", done); end
    step();
    checks++;
    if ({rd_cnt - r0, psum_cnt - p0, done_cnt - d0} !== {32'd1, 32'd1, 32'd1}) begin
      failures++; $display("FAIL zero_counts got=%0d/%0d/%0d exp=1/1/1", rd_cnt - r0, psum_cnt - p0, done_cnt - d0);
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    logic [6:0] obs;
    d0 = done_cnt;
    psum_ready = 1'b1;
    kick(4'd3, 4'd2, 4'd1);
    win_valid = 1'b1;
    step();
    win_valid = 1'b0;
    step();
    step();
    step();
    checks++;
    if (spad_addr !== 8'd3) begin failures++; $display("FAIL rmid_pre got=%0d exp=3", spad_addr); end
    rstn = 1'b0;
    step();
    obs = {win_ready, spad_rd_en, mac_en, mac_first, psum_valid, busy, done};
    checks++;
    if ({obs, spad_addr} !== 15'd0) begin failures++; $display("FAIL rmid_outputs got=%b/%0d exp=0/0", obs, spad_addr); end
    rstn = 1'b1;
    step();
    kick(4'd4, 4'd1, 4'd1);
    win_valid = 1'b1;
    step();
    win_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({spad_rd_en, spad_addr} !== {1'b1, 8'(i)}) begin failures++; $display("FAIL rmid_addr[%0d] got=%0d exp=%0d", i, spad_addr, i); end
      step();
    end
    checks++;
    if (spad_rd_en !== 1'b0) begin failures++; $display("FAIL rmid_end got=%b exp=0", spad_rd_en); end
    step();
    step();
    step();
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL rmid_done got=%b exp=1", done); end
    step();
    checks++;
    if (done_cnt - d0 !== 1) begin failures++; $display("FAIL rmid_done_count got=%0d exp=1", done_cnt - d0); end
  endtask

  task automatic test_start_abuse();
    int d0;
    d0 = done_cnt;
    psum_ready = 1'b1;
    kick(4'd2, 4'd2, 4'd1);
    start = 1'b1;
    cfg_filt_len = 4'd5;
    cfg_num_ch   = 4'd3;
    cfg_num_win  = 4'd2;
    step();
    checks++;
    if ({busy, win_ready} !== 2'b11) begin failures++; $display("FAIL abuse_wait got=%b exp=11", {busy, win_ready}); end
    win_valid = 1'b1;
    step();
    win_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({spad_rd_en, spad_addr} !== {1'b1, 8'(i)}) begin failures++; $display("FAIL abuse_addr[%0d] got=%0d exp=%0d", i, spad_addr, i); end
      step();
    end
    start = 1'b0;
    checks++;
    if (spad_rd_en !== 1'b0) begin failures++; $display("FAIL abuse_end got=%b exp=0", spad_rd_en); end
    step();
    step();
    checks++;
    if (psum_valid !== 1'b1) begin failures++; $display("FAIL abuse_psum got=%b exp=1", psum_valid); end
    step();
    checks++;
    if (done !== 1'b1) begin failures++; $display("FAIL abuse_done got=%b exp=1", done); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({busy, win_ready} !== 2'b00) begin failures++; $display("FAIL abuse_done_start got=%b exp=00", {busy, win_ready}); end
    step();
    checks++;
    if ({busy, done_cnt - d0} !== {1'b0, 32'd1}) begin
      failures++; $display("FAIL abuse_final got=%b/%0d exp=0/1", busy, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_zero();
    test_reset_mid();
    test_start_abuse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pe_spad_seq.md
PE_SPAD_SEQ -- requirements
Module: pe_spad_seq

Interface
REQ-001 Parameter CNT_W, default 4, width of each loop-bound and loop-index field.
REQ-002 Parameter ADDR_W, default 8, scratchpad address width; ADDR_W SHALL be at least 2*CNT_W.
REQ-003 Parameter DRAIN_CYC, default 2, MAC pipeline cycles between the last mac_en and a settled psum.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rstn  in  1  reset; synchronous, active-low.
REQ-006 start  in  1  one-cycle pulse that begins a pass; ignored while busy=1.
REQ-007 cfg_filt_len  in  CNT_W  filter taps per channel (S); sampled on an accepted start.
REQ-008 cfg_num_ch  in  CNT_W  channels per window (C); sampled on an accepted start.
REQ-009 cfg_num_win  in  CNT_W  windows per pass (W); sampled on an accepted start.
REQ-010 win_valid  in  1  upstream has loaded an ifmap window into the scratchpad.
REQ-011 win_ready  out  1  sequencer accepts a window; a transfer occurs when win_valid and win_ready are both 1.
REQ-012 spad_rd_en  out  1  scratchpad read strobe.
REQ-013 spad_addr  out  ADDR_W  scratchpad read address, valid when spad_rd_en=1.
REQ-014 mac_en  out  1  MAC accumulate enable.
REQ-015 mac_first  out  1  qualifies mac_en; MAC loads rather than accumulates.
REQ-016 psum_valid  out  1  partial sum available to downstream.
REQ-017 psum_ready  in  1  downstream accepts the psum; a transfer occurs when psum_valid and psum_ready are both 1.
REQ-018 busy  out  1  high from an accepted start until done.
REQ-019 done  out  1  one-cycle pulse after the final psum transfer.

Function
REQ-020 The FSM SHALL have exactly these states: IDLE, WAIT_WIN, READ, DRAIN, OUT.
REQ-021 IDLE->WAIT_WIN on start; this SHALL latch the cfg values, clear all loop indices, and set busy.
REQ-022 win_ready SHALL be 1 only in WAIT_WIN; WAIT_WIN->READ on a win handshake.
REQ-023 READ SHALL assert spad_rd_en every cycle, with spad_addr = c*S + s.
REQ-024 spad_addr SHALL be formed from an incrementing base register (base += S on channel advance), not a multiplier.
REQ-025 Loop order in READ: s is innermost (0..S-1), then c (0..C-1); s wraps to 0 when c advances.
REQ-026 A cfg value of 0 SHALL be treated as 1.
REQ-027 Each loop index SHALL compare against bound-1 using >= (saturating terminal).
REQ-028 READ->DRAIN in the cycle after the read with s=S-1 and c=C-1; READ SHALL last exactly S*C cycles.
REQ-029 mac_en SHALL equal spad_rd_en delayed by one cycle.
REQ-030 mac_first SHALL equal (s==0 and c==0) delayed by one cycle.
REQ-031 DRAIN SHALL last exactly DRAIN_CYC cycles after the last mac_en, then go to OUT.
REQ-032 OUT SHALL hold psum_valid=1 until psum_ready=1, and no other output SHALL change during the stall.
REQ-033 On the psum handshake: if w==W-1 go to IDLE, pulse done, and clear busy in the same cycle; otherwise increment w and go to WAIT_WIN.
REQ-034 start arriving in the same cycle as done SHALL be ignored; a start is accepted only in IDLE.
REQ-035 cfg input changes while busy SHALL have no effect on the current pass.

Reset
REQ-036 While rstn=0 at a clock edge: state=IDLE, all loop indices and the base register = 0.
REQ-037 While rstn=0 at a clock edge: win_ready, spad_rd_en, mac_en, mac_first, psum_valid, busy, done = 0, and spad_addr = 0.
REQ-038 rstn=0 in any state, including mid-READ or OUT, SHALL abort the pass without emitting done.

Structure
REQ-039 The FSM state encoding and the DRAIN_CYC default SHALL live in a shared package, pe_ctrl_pkg.
REQ-040 The loop indices SHALL be built from one sub-module, pe_loop_counter, instantiated three times (s, c, w).
REQ-041 pe_loop_counter is a saturating up-counter with en, clear, max_count inputs and an at_max output.

Verification
REQ-042 Single window: S=3, C=2, W=1, psum_ready=1 -> addresses 0,1,2,3,4,5 on 6 consecutive cycles; mac_first only on the 1st mac_en; psum_valid 2 cycles after the last mac_en; done one cycle after the handshake.
REQ-043 Multi-window with backpressure: S=2, C=1, W=3, psum_ready held low 5 cycles per window -> psum_valid stable throughout; 3 handshakes; win_ready asserted 3 times; exactly one done.
REQ-044 Zero configuration: S=0, C=0, W=0 -> exactly one read at addr 0, one psum, one done.
REQ-045 Reset mid-pass: rstn low during READ at c=1 -> all outputs 0 next cycle, no done; a following start with S=4, C=1, W=1 -> addresses 0..3.
REQ-046 Start abuse: start pulsed while busy and in the done cycle -> ignored; cfg changed mid-pass -> current addresses unchanged.
